// File: rtl/fp_pkg.sv
// Shared types and default widths for the sequential floating-point multiplier.
// Pure declarations; no logic, no latency, no handshake.
// Imported by fp_classify and fp_mult_seq.
package fp_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;

  typedef enum logic [1:0] {IDLE, MULT, NORM, DONE} state_t;

  typedef enum logic [1:0] {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN} fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Classifies one operand as zero (denormals included), normal, infinity or NaN.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fp_classify
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] man,
  output fp_class_t        cls
);

  always_comb begin
    cls = FP_NORMAL;
    if (exp == '0) begin
      cls = FP_ZERO;
    end else if (exp == '1) begin
      cls = (man == '0) ? FP_INF : FP_NAN;
    end
  end

endmodule

// File: rtl/fp_mult_seq.sv
// Multicycle FP multiplier: shift-add mantissa product, one multiplier bit per cycle.
// Latency: accept + MAN_W+3 cycles for normal operands, accept + 1 for special operands.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready. Define FP_MULT_ROUND_NEAREST_EN for RNE, else truncate.
module fp_mult_seq
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   x,
  input  logic [EXP_W+MAN_W:0]   y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   zero,
  output logic                   underflow,
  output logic                   overflow,
  output logic                   nan
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int P     = MAN_W + 1;
  localparam int CNT_W = $clog2(P);
  localparam int E_W   = EXP_W + 2;

  localparam logic [E_W-1:0] BIAS  = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic [E_W-1:0] E_MAX = E_W'((1 << EXP_W) - 1);
  localparam logic [W-1:0]   QNAN  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t    state, state_nxt;
  fp_class_t cls_x, cls_y;

  logic             sign_q;
  logic [EXP_W-1:0] ex_q, ey_q;
  logic [2*P-1:0]   acc, mcand;
  logic [P-1:0]     mplier;
  logic [CNT_W-1:0] cnt;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_x (
    .exp (x[W-2 -: EXP_W]),
    .man (x[MAN_W-1:0]),
    .cls (cls_x)
  );

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_y (
    .exp (y[W-2 -: EXP_W]),
    .man (y[MAN_W-1:0]),
    .cls (cls_y)
  );

  logic sign_in, both_norm, spec_nan, spec_inf;
  assign sign_in   = x[W-1] ^ y[W-1];
  assign both_norm = (cls_x == FP_NORMAL) && (cls_y == FP_NORMAL);
  assign spec_nan  = (cls_x == FP_NAN) || (cls_y == FP_NAN) ||
                     ((cls_x == FP_INF) && (cls_y == FP_ZERO)) ||
                     ((cls_x == FP_ZERO) && (cls_y == FP_INF));
  assign spec_inf  = (cls_x == FP_INF) || (cls_y == FP_INF);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = both_norm ? MULT : DONE;
      MULT:    if (cnt == CNT_W'(MAN_W)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Product lies in [1,4): align so the leading one is dropped and the fraction sits on top.
  logic [2*P-2:0]   norm;
  logic [MAN_W-1:0] man_t, man_fin;
  logic [MAN_W:0]   man_rnd;
  logic [E_W-1:0]   e_pre, e_fin;
  logic             ovf, unf;

  assign norm  = acc[2*P-1] ? acc[2*P-2:0] : {acc[2*P-3:0], 1'b0};
  assign man_t = norm[2*P-2 -: MAN_W];
  assign e_pre = {2'b00, ex_q} + {2'b00, ey_q} - BIAS + E_W'(acc[2*P-1]);

`ifdef FP_MULT_ROUND_NEAREST_EN
  logic guard, sticky;
  assign guard   = norm[MAN_W];
  assign sticky  = |norm[MAN_W-1:0];
  assign man_rnd = {1'b0, man_t} + (MAN_W+1)'(guard & (sticky | man_t[0]));
`else
  logic unused_low;
  assign unused_low = ^norm[MAN_W:0];
  assign man_rnd    = {1'b0, man_t};
`endif

  assign e_fin   = e_pre + E_W'(man_rnd[MAN_W]);
  assign man_fin = man_rnd[MAN_W] ? '0 : man_rnd[MAN_W-1:0];
  assign ovf     = !e_fin[E_W-1] && (e_fin >= E_MAX);
  assign unf     = e_fin[E_W-1] || (e_fin == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      sign_q    <= 1'b0;
      ex_q      <= '0;
      ey_q      <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      result    <= '0;
      zero      <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      nan       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_q <= sign_in;
          ex_q   <= x[W-2 -: EXP_W];
          ey_q   <= y[W-2 -: EXP_W];
          mcand  <= {{P{1'b0}}, 1'b1, x[MAN_W-1:0]};
          mplier <= {1'b1, y[MAN_W-1:0]};
          acc    <= '0;
          cnt    <= '0;
          if (!both_norm) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
            nan       <= spec_nan;
            zero      <= !spec_nan && !spec_inf;
            if (spec_nan)      result <= QNAN;
            else if (spec_inf) result <= {sign_in, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            else               result <= {sign_in, {(W-1){1'b0}}};
          end
        end
        MULT: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        NORM: begin
          nan       <= 1'b0;
          overflow  <= ovf;
          underflow <= unf && !ovf;
          zero      <= unf && !ovf;
          if (ovf)      result <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          else if (unf) result <= {sign_q, {(W-1){1'b0}}};
          else          result <= {sign_q, e_fin[EXP_W-1:0], man_fin};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Scoreboard bench for fp_mult_seq (single precision): directed corner cases plus
// random operands checked against an integer-arithmetic reference model.
module tb_fp_mult_seq;

  logic        clk, reset, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] x, y, result;
  logic        zero, underflow, overflow, nan;

  fp_mult_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .underflow(underflow),
    .overflow(overflow), .nan(nan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, b, r;
    logic [3:0]  f;     // {zero, underflow, overflow, nan}
    int          acc;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t e_m;
  int   errors = 0, checks = 0, cyc = 0, n_xfer = 0;
  bit   seen = 1'b0, rand_rdy = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: exact integer product, rounded by comparing the discarded remainder to half an ulp.
  function automatic void ref_mul(input logic [31:0] a, b, output logic [31:0] r,
                                  output logic [3:0] f, output int lat);
    logic s; int ea, eb, e, sh; longint ma, mb, p, frac;
    bit za, zb, ia, ib, na, nb;
`ifdef FP_MULT_ROUND_NEAREST_EN
    longint rem, half;
`endif
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ma = longint'(a[22:0]); mb = longint'(b[22:0]);
    za = (ea == 0); zb = (eb == 0);
    ia = (ea == 255) && (ma == 0); ib = (eb == 255) && (mb == 0);
    na = (ea == 255) && (ma != 0); nb = (eb == 255) && (mb != 0);
    f = 4'b0000; lat = 1;
    if (na || nb || (ia && zb) || (za && ib)) begin
      r = 32'h7FC00000; f = 4'b0001;
    end else if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
    end else if (za || zb) begin
      r = {s, 31'h0}; f = 4'b1000;
    end else begin
      lat = 26;
      p = (ma + 64'd8388608) * (mb + 64'd8388608);
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin e++; sh = 24; end else sh = 23;
      frac = p >> sh;
`ifdef FP_MULT_ROUND_NEAREST_EN
      rem  = p - (frac << sh);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && frac[0])) frac++;
      if (frac == (64'd1 << 24)) begin frac = 64'd1 << 23; e++; end
`endif
      if (e >= 255)    begin r = {s, 8'hFF, 23'h0}; f = 4'b0010; end
      else if (e <= 0) begin r = {s, 31'h0};        f = 4'b1100; end
      else               r = {s, e[7:0], frac[22:0]};
    end
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 9);
    if (k == 0) begin
      case ($urandom_range(0, 4))
        0:       v = {v[31], 31'h0};
        1:       v = {v[31], 8'hFF, 23'h0};
        2:       v = {v[31], 8'hFF, v[22:0] | 23'h1};
        3:       v = {v[31], 8'h00, v[22:0]};
        default: v = {v[31], 8'hFE, v[22:0]};
      endcase
    end else if (k > 2) begin
      v[30:23] = 8'($urandom_range(64, 190));
    end
    return v;
  endfunction

  // Monitor: latency on first out_valid, then result/flags when the transfer happens.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out_valid", {31'h0, out_valid}, 32'h0);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          check($sformatf("latency %h*%h", exp_q[0].a, exp_q[0].b),
                cyc - exp_q[0].acc, exp_q[0].lat);
        end
        if (out_ready) begin
          e_m = exp_q.pop_front();
          seen = 1'b0;
          n_xfer++;
          check($sformatf("result %h*%h", e_m.a, e_m.b), result, e_m.r);
          check($sformatf("flags %h*%h", e_m.a, e_m.b),
                {28'h0, zero, underflow, overflow, nan}, {28'h0, e_m.f});
        end
      end
    end
  end

  initial begin
    @(posedge clk);
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [31:0] a, b, r, input logic [3:0] f, input int lat);
    exp_t e;
    @(negedge clk);
    x = a; y = b; in_valid = 1'b1;
    for (int k = 0; k < 200 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      check("accept_timeout", {31'h0, in_ready}, 32'h1);
      in_valid = 1'b0;
      return;
    end
    e.a = a; e.b = b; e.r = r; e.f = f; e.acc = cyc; e.lat = lat;
    exp_q.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 400 && !(in_ready && exp_q.size() == 0); k++) @(negedge clk);
    check("idle_reached", {31'h0, in_ready && exp_q.size() == 0}, 32'h1);
  endtask

`ifdef FP_MULT_ROUND_NEAREST_EN
  localparam logic [31:0] SQ_RES = 32'h40100002;
`else
  localparam logic [31:0] SQ_RES = 32'h40100001;
`endif

  logic [31:0] dx [7] = '{32'h3FC00000, 32'h3FC00001, 32'h7F000000, 32'h00800000,
                          32'h7F800000, 32'hFF800000, 32'h80000000};
  logic [31:0] dy [7] = '{32'h40000000, 32'h3FC00001, 32'h40000000, 32'h3F000000,
                          32'h00000000, 32'h40000000, 32'h3F800000};
  logic [31:0] dr [7] = '{32'h40400000, SQ_RES, 32'h7F800000, 32'h00000000,
                          32'h7FC00000, 32'hFF800000, 32'h80000000};
  logic [3:0]  df [7] = '{4'b0000, 4'b0000, 4'b0010, 4'b1100, 4'b0001, 4'b0000, 4'b1000};
  int          dl [7] = '{26, 26, 26, 26, 1, 1, 1};

  initial begin
    #600000;
    $display("FAIL global_timeout: cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [31:0] ra, rb, rr;
    logic [3:0]  rf;
    int          rl, base;
    bit          ok;

    reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", {31'h0, out_valid}, 32'h0);
    check("reset_result", result, 32'h0);
    check("reset_flags", {28'h0, zero, underflow, overflow, nan}, 32'h0);
    check("reset_in_ready", {31'h0, in_ready}, 32'h1);

    // Directed cases; the first also watches in_ready while busy.
    for (int i = 0; i < 7; i++) begin
      send(dx[i], dy[i], dr[i], df[i], dl[i]);
      if (i == 0) begin
        ok = 1'b1;
        for (int k = 0; k < 40 && !out_valid; k++) begin
          if (in_ready) ok = 1'b0;
          @(negedge clk);
        end
        check("in_ready_low_while_busy", {31'h0, ok}, 32'h1);
      end
      wait_idle();
    end

    // Stall in DONE for 5 cycles, with new operands offered meanwhile.
    @(posedge clk); #1 out_ready = 1'b0;
    send(32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0001, 1);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!out_valid || in_ready || result !== 32'h7FC00000 || !nan) ok = 1'b0;
      x = 32'h3F800000; y = 32'h40000000; in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("stall_hold", {31'h0, ok}, 32'h1);
    base = n_xfer;
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("stall_one_transfer", n_xfer - base, 1);
    check("stall_back_idle", {30'h0, out_valid, in_ready}, 32'h1);
    check("stall_result_kept", result, 32'h7FC00000);
    wait_idle();

    // Abort a multiply with reset 10 cycles into MULT.
    send(32'h40400000, 32'h40400000, 32'h41100000, 4'b0000, 26);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    seen = 1'b0;
    check("abort_state", {30'h0, out_valid, in_ready}, 32'h1);
    send(32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 26);
    wait_idle();

    // Random operands against the reference model, with random output stalls.
    @(posedge clk); #1 rand_rdy = 1'b1;
    for (int n = 0; n < 150; n++) begin
      ra = rnd_op(); rb = rnd_op();
      ref_mul(ra, rb, rr, rf, rl);
      send(ra, rb, rr, rf, rl);
    end
    @(posedge clk); #1 rand_rdy = 1'b0; out_ready = 1'b1;
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_mult_seq.md
Name: fp_mult_seq

Overview:
- Parametrised, multicycle floating-point multiplier. It is the successor to the lab's combinational single-precision multiplier.
- Generic exponent and mantissa widths.
- Iterative shift-add mantissa multiply, driven by an FSM.
- Full special-case handling: zero, infinity, NaN, overflow, underflow.
- Valid/ready handshake on input and output, so it drops into datapaths that tolerate variable latency.

Parameters:
- EXP_W, 8: exponent field width. Bias = 2^(EXP_W-1)-1.
- MAN_W, 23: stored mantissa (fraction) width. Total word width W = 1+EXP_W+MAN_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands x, y valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- x  in  W  operand A: {sign, exp, man}.
- y  in  W  operand B.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts result.
- result  out  W  product.
- zero  out  1  result is ±0.
- underflow  out  1  exact result below min normal; flushed to ±0.
- overflow  out  1  finite operands produced ±inf.
- nan  out  1  result is NaN.

Behaviour:
- Reset: state=IDLE, out_valid=0, result=0, all flags=0, in_ready=1 from the next cycle. Reset mid-operation aborts the operation with no output.
- Accept occurs when in_valid && in_ready. The operands are latched and each is classified:
  - zero: exp==0. Denormals are treated as zero.
  - inf: exp all-ones, man==0.
  - nan: exp all-ones, man!=0.
  - normal: otherwise.
- Special path (any operand not normal): IDLE -> DONE, with out_valid high 1 cycle after accept.
  - NaN if any operand is NaN, or inf*zero. Result = canonical quiet NaN: sign 0, exp all-ones, man MSB 1, rest 0. nan=1.
  - inf * (inf or normal): result ±inf, overflow=0.
  - zero * (zero or normal): result ±0, zero=1.
- Normal path: IDLE -> MULT -> NORM -> DONE.
  - MULT: MAN_W+1 cycles, one multiplier bit per cycle (LSB first). Add the shifted multiplicand {1,man_x} into a 2*(MAN_W+1)-bit accumulator.
  - NORM (1 cycle):
    - If the product MSB is set, shift right 1 and add 1 to the exponent.
    - Exponent math: signed EXP_W+2 bits, e = ex + ey - bias.
    - Apply rounding (see Optional Feature). A rounding carry-out renormalises (man=0, e+1).
  - DONE: out_valid=1 at accept + MAN_W+3 cycles (26 for default parameters).
- Range checks in NORM:
  - e >= 2^EXP_W - 1: result ±inf, overflow=1.
  - e <= 0: result ±0, underflow=1, zero=1.
  - Otherwise a normal result, all flags 0.
- Sign = x.sign ^ y.sign on every path except NaN.
- DONE holds result, flags and out_valid stable until out_ready. On out_valid && out_ready, go to IDLE: out_valid=0 next cycle, and result/flags keep their last value.
- No overlap: in_ready=0 in MULT, NORM and DONE. in_valid is ignored outside IDLE.
- Simultaneous out_ready and reset: reset wins.

Optional Feature:
- Macro FP_MULT_ROUND_NEAREST_EN.
- Defined: round-to-nearest-even, using guard bit, and sticky = OR of the remaining discarded bits.
- Undefined: truncate (round toward zero). Guard and sticky logic are absent.
- Flags and latency are identical in both builds.

Decomposition:
- Package fp_pkg holds:
  - State enum {IDLE, MULT, NORM, DONE}.
  - fp_class_t enum {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN}.
  - Default EXP_W/MAN_W localparams.
- Sub-module fp_classify (combinational, parametrised by EXP_W/MAN_W): operand in, fp_class_t out. Instantiated twice.
- The FSM, accumulator and normaliser live in fp_mult_seq.

Test Plan:
- 0x3FC00000 * 0x40000000 (1.5*2) -> 0x40400000, all flags 0, out_valid exactly 26 cycles after accept, in_ready low throughout.
- 0x3FC00001 * 0x3FC00001 -> 0x40100001 without FP_MULT_ROUND_NEAREST_EN, 0x40100002 with it. Also checks normalisation shift.
- 0x7F000000 * 0x40000000 -> 0x7F800000 with overflow=1. 0x00800000 * 0x3F000000 -> 0x00000000 with underflow=1, zero=1.
- 0x7F800000 * 0x00000000 -> 0x7FC00000 with nan=1. 0xFF800000 * 0x40000000 -> 0xFF800000, all flags 0. 0x80000000 * 0x3F800000 -> 0x80000000 with zero=1. Each specials case has out_valid 1 cycle after accept.
- Hold out_ready low 5 cycles in DONE: result and out_valid stable, in_ready=0, new in_valid ignored. Release: one transfer, then IDLE.
- Assert reset 10 cycles into MULT: next cycle IDLE with in_ready=1, out_valid=0. A following 1.0*1.0 (0x3F800000) -> 0x3F800000.
